// File: rtl/mem_dcache_ctrl.sv
// MEM-stage data-memory access controller.
// Converts a MEM-stage load/store into a DCache request/response handshake, stalls the upstream
// pipeline while the access is outstanding, and extends load data for writeback.
// Optional feature: define MEM_ALIGN_CHECK_EN to flag misaligned half/word accesses on mem_ale
// instead of issuing them.
module mem_dcache_ctrl #(
    parameter int unsigned WORD = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid,
    input  logic            mem_we,
    input  logic [1:0]      mem_size,
    input  logic            mem_unsigned,
    input  logic [WORD-1:0] mem_addr,
    input  logic [WORD-1:0] mem_wdata,
    output logic            dc_req,
    output logic            dc_we,
    output logic [WORD-1:0] dc_addr,
    output logic [3:0]      dc_wstrb,
    output logic [WORD-1:0] dc_wdata,
    input  logic            dc_ready,
    input  logic            dc_rvalid,
    input  logic [WORD-1:0] dc_rdata,
    output logic            mem_stall,
    output logic            MEM_WB_flush_from_DCache,
    output logic [WORD-1:0] mem_rdata,
    output logic            mem_ale
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e          state_q;
    logic            we_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic [WORD-1:0] addr_q;
    logic [WORD-1:0] wdata_q;
    logic [WORD-1:0] rdata_q;

    logic            idle;
    logic            misaligned;
    logic            issue;
    logic            req;
    logic            sel_we;
    logic [1:0]      sel_size;
    logic [WORD-1:0] sel_addr;
    logic [WORD-1:0] sel_wdata;

    // Byte write strobes for the addressed lane(s).
    function automatic logic [3:0] strb_f(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   strb_f = 4'b0001 << a;
            2'b01:   strb_f = a[1] ? 4'b1100 : 4'b0011;
            default: strb_f = 4'hF;
        endcase
    endfunction

    // Store data replicated across lanes so the strobes pick the right copy.
    function automatic logic [31:0] wdata_f(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   wdata_f = {4{wd[7:0]}};
            2'b01:   wdata_f = {2{wd[15:0]}};
            default: wdata_f = wd;
        endcase
    endfunction

    // Lane select plus sign/zero extension of the raw load word.
    function automatic logic [31:0] ext_f(input logic [1:0] size, input logic uns,
                                          input logic [1:0] a, input logic [31:0] raw);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = raw[7:0];
            2'd1:    b = raw[15:8];
            2'd2:    b = raw[23:16];
            default: b = raw[31:24];
        endcase
        h = a[1] ? raw[31:16] : raw[15:0];
        case (size)
            2'b00:   ext_f = {{24{~uns & b[7]}}, b};
            2'b01:   ext_f = {{16{~uns & h[15]}}, h};
            default: ext_f = raw;
        endcase
    endfunction

    // Alignment check and request-field selection (live inputs in IDLE, latched copy in REQ).
    always_comb begin
        idle = (state_q == StIdle);
`ifdef MEM_ALIGN_CHECK_EN
        case (mem_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = mem_addr[0];
            default: misaligned = (mem_addr[1:0] != 2'b00);
        endcase
`else
        misaligned = 1'b0;
`endif
        issue     = idle & mem_valid & ~misaligned;
        req       = issue | (state_q == StReq);
        sel_we    = idle ? mem_we    : we_q;
        sel_size  = idle ? mem_size  : size_q;
        sel_addr  = idle ? mem_addr  : addr_q;
        sel_wdata = idle ? mem_wdata : wdata_q;
    end

    // Output drive; everything is held at zero while rst is high.
    always_comb begin
        dc_req    = ~rst & req;
        dc_we     = ~rst & req & sel_we;
        dc_addr   = (~rst & req) ? {sel_addr[WORD-1:2], 2'b00} : '0;
        dc_wstrb  = (~rst & req & sel_we) ? strb_f(sel_size, sel_addr[1:0]) : 4'h0;
        dc_wdata  = (~rst & req & sel_we) ? wdata_f(sel_size, sel_wdata) : '0;
        mem_stall = ~rst & (issue | (state_q == StReq) | (state_q == StWait));
        mem_ale   = ~rst & idle & mem_valid & misaligned;
        // A misaligned op flushes for one cycle without stalling.
        MEM_WB_flush_from_DCache = mem_stall | mem_ale;
        mem_rdata = rst ? '0 : rdata_q;
    end

    // Request FSM, request latch and load-result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (issue) begin
                        we_q    <= mem_we;
                        size_q  <= mem_size;
                        uns_q   <= mem_unsigned;
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        state_q <= dc_ready ? StWait : StReq;
                    end
                end
                StReq: begin
                    if (dc_ready) state_q <= StWait;
                end
                StWait: begin
                    if (dc_rvalid) begin
                        // Stores complete without touching the load result.
                        if (!we_q) rdata_q <= ext_f(size_q, uns_q, addr_q[1:0], dc_rdata);
                        state_q <= StDone;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dcache_ctrl.sv
// Directed bench for mem_dcache_ctrl: table of single accesses plus hand-written sequences for
// reset-in-WAIT, stale responses and (when MEM_ALIGN_CHECK_EN is defined) misaligned ops.
module tb_mem_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_we, mem_unsigned;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        dc_req, dc_we;
    logic [31:0] dc_addr, dc_wdata, dc_rdata;
    logic [3:0]  dc_wstrb;
    logic        dc_ready, dc_rvalid;
    logic        mem_stall, flush, mem_ale;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    mem_dcache_ctrl #(.WORD(32)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .mem_valid                (mem_valid),
        .mem_we                   (mem_we),
        .mem_size                 (mem_size),
        .mem_unsigned             (mem_unsigned),
        .mem_addr                 (mem_addr),
        .mem_wdata                (mem_wdata),
        .dc_req                   (dc_req),
        .dc_we                    (dc_we),
        .dc_addr                  (dc_addr),
        .dc_wstrb                 (dc_wstrb),
        .dc_wdata                 (dc_wdata),
        .dc_ready                 (dc_ready),
        .dc_rvalid                (dc_rvalid),
        .dc_rdata                 (dc_rdata),
        .mem_stall                (mem_stall),
        .MEM_WB_flush_from_DCache (flush),
        .mem_rdata                (mem_rdata),
        .mem_ale                  (mem_ale)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [31:0] exp_rd;
        logic [31:0] exp_addr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wd;
        int          rdy;   // cycles dc_ready stays low before accept
        int          rv;    // extra WAIT cycles before dc_rvalid
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One access: drive it, step dc_ready/dc_rvalid per the record, check every cycle to DONE.
    task automatic do_op(input vec_t v, input int idx);
        int   cyc;
        int   total;
        bit   fin;
        logic [31:0] exp_rd;
        cyc   = 0;
        fin   = 0;
        total = v.rdy + v.rv + 2;
        exp_rd = v.we ? last_rd : v.exp_rd;
        while (!fin && cyc < 40) begin
            @(posedge clk); #1;
            if (cyc == 0) begin
                mem_valid    = 1'b1;
                mem_we       = v.we;
                mem_size     = v.size;
                mem_unsigned = v.uns;
                mem_addr     = v.addr;
                mem_wdata    = v.wd;
                dc_rdata     = v.rd;
            end
            dc_ready  = (cyc == v.rdy);
            dc_rvalid = (cyc == v.rdy + 1 + v.rv);
            @(negedge clk);
            chk($sformatf("v%0d c%0d dc_req", idx, cyc), 32'(dc_req), 32'(cyc <= v.rdy));
            if (cyc <= v.rdy) begin
                chk($sformatf("v%0d c%0d dc_addr", idx, cyc), dc_addr, v.exp_addr);
                chk($sformatf("v%0d c%0d dc_we", idx, cyc), 32'(dc_we), 32'(v.we));
                chk($sformatf("v%0d c%0d dc_wstrb", idx, cyc), 32'(dc_wstrb), 32'(v.exp_strb));
                if (v.we) chk($sformatf("v%0d c%0d dc_wdata", idx, cyc), dc_wdata, v.exp_wd);
            end
            if (cyc < total) begin
                chk($sformatf("v%0d c%0d stall", idx, cyc), 32'(mem_stall), 32'd1);
                chk($sformatf("v%0d c%0d flush", idx, cyc), 32'(flush), 32'd1);
            end else begin
                chk($sformatf("v%0d done stall", idx), 32'(mem_stall), 32'd0);
                chk($sformatf("v%0d done flush", idx), 32'(flush), 32'd0);
                chk($sformatf("v%0d done mem_rdata", idx), mem_rdata, exp_rd);
                chk($sformatf("v%0d done ale", idx), 32'(mem_ale), 32'd0);
                fin = 1;
            end
            cyc++;
        end
        if (!fin) begin
            n_tests++;
            n_fail++;
            $display("FAIL v%0d timeout: got no DONE, expected one within 40 cycles", idx);
        end
        dc_ready  = 1'b0;
        dc_rvalid = 1'b0;
        last_rd   = exp_rd;
    endtask

    task automatic idle_inputs();
        mem_valid = 1'b0; mem_we = 1'b0; mem_size = 2'b00; mem_unsigned = 1'b0;
        mem_addr  = '0;   mem_wdata = '0; dc_ready = 1'b0; dc_rvalid = 1'b0; dc_rdata = '0;
    endtask

    initial begin
        //             we size uns addr          wd            rd            exp_rd
        //             exp_addr      strb     exp_wd        rdy rv
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h89ABCDEF, 32'h89ABCDEF,
                         32'h100, 4'h0, 32'h0, 0, 0});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FFFFFF, 32'hFFFFFF80,
                         32'h100, 4'h0, 32'h0, 0, 0});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FFFFFF, 32'h00000080,
                         32'h100, 4'h0, 32'h0, 1, 0});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h80017FFF, 32'hFFFF8001,
                         32'h100, 4'h0, 32'h0, 0, 1});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 32'h80017FFF, 32'h00007FFF,
                         32'h100, 4'h0, 32'h0, 0, 0});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'h12345678, 32'h00000056,
                         32'h100, 4'h0, 32'h0, 0, 0});
        vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h301, 32'hAABBCCDD, 32'hFFFFFFFF, 32'h0,
                         32'h300, 4'b0010, 32'hDDDDDDDD, 0, 0});
        vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h202, 32'h00001234, 32'h0, 32'h0,
                         32'h200, 4'b1100, 32'h12341234, 3, 0});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h404, 32'hCAFEF00D, 32'h0, 32'h0,
                         32'h404, 4'hF, 32'hCAFEF00D, 1, 2});
        vecs.push_back('{1'b0, 2'b11, 1'b0, 32'h010, 32'h0, 32'h13579BDF, 32'h13579BDF,
                         32'h010, 4'h0, 32'h0, 0, 0});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h102, 32'h0, 32'h00FF0000, 32'h000000FF,
                         32'h100, 4'h0, 32'h0, 0, 0});
`ifndef MEM_ALIGN_CHECK_EN
        // Without the alignment check, low address bits only pick lanes.
        vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h103, 32'h0, 32'hBEEF0000, 32'hFFFFBEEF,
                         32'h100, 4'h0, 32'h0, 0, 0});
        vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h003, 32'h0000ABCD, 32'h0, 32'h0,
                         32'h000, 4'b1100, 32'hABCDABCD, 0, 0});
`endif

        // Reset with live inputs: all outputs forced low.
        idle_inputs();
        rst = 1'b1;
        mem_valid = 1'b1; mem_we = 1'b1; mem_size = 2'b10; mem_addr = 32'h55;
        mem_wdata = 32'hFFFFFFFF; dc_ready = 1'b1; dc_rvalid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst dc_req", 32'(dc_req), 32'd0);
        chk("rst dc_we", 32'(dc_we), 32'd0);
        chk("rst dc_addr", dc_addr, 32'd0);
        chk("rst dc_wstrb", 32'(dc_wstrb), 32'd0);
        chk("rst dc_wdata", dc_wdata, 32'd0);
        chk("rst stall", 32'(mem_stall), 32'd0);
        chk("rst flush", 32'(flush), 32'd0);
        chk("rst mem_ale", 32'(mem_ale), 32'd0);
        chk("rst mem_rdata", mem_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        chk("idle stall", 32'(mem_stall), 32'd0);
        chk("idle dc_req", 32'(dc_req), 32'd0);
        last_rd = 32'h0;

        // Table, issued back-to-back: each op must request in the cycle after the previous DONE.
        foreach (vecs[i]) do_op(vecs[i], i);

        // Reset while in WAIT, then a stale response must be ignored.
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 32'h20; dc_ready = 1'b1;
        @(negedge clk);
        chk("rstwait issue", 32'(dc_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; dc_ready = 1'b0;
        @(negedge clk);
        chk("rstwait stall", 32'(mem_stall), 32'd0);
        chk("rstwait rdata", mem_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; mem_valid = 1'b0; dc_rvalid = 1'b1; dc_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("stale stall", 32'(mem_stall), 32'd0);
        chk("stale dc_req", 32'(dc_req), 32'd0);
        @(posedge clk); #1;
        dc_rvalid = 1'b0;
        @(negedge clk);
        chk("stale rdata", mem_rdata, 32'd0);
        chk("stale flush", 32'(flush), 32'd0);
        last_rd = 32'h0;
        begin
            vec_t v;
            v = '{1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0BADF00D, 32'h0BADF00D,
                  32'h40, 4'h0, 32'h0, 0, 0};
            do_op(v, 99);
        end

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned word load: one-cycle flush/ale, no request, no stall, stays IDLE.
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 32'h101; dc_ready = 1'b1;
        @(negedge clk);
        chk("ale flag", 32'(mem_ale), 32'd1);
        chk("ale flush", 32'(flush), 32'd1);
        chk("ale dc_req", 32'(dc_req), 32'd0);
        chk("ale stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        mem_valid = 1'b0; dc_ready = 1'b0;
        @(negedge clk);
        chk("ale clear", 32'(mem_ale), 32'd0);
        chk("ale flush clear", 32'(flush), 32'd0);
        chk("ale rdata kept", mem_rdata, last_rd);
`endif

        @(posedge clk); #1;
        idle_inputs();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
